// File: rtl/legv8_pkg.sv
// Shared LEGv8 front-end definitions: instruction classes, issue FSM states and PC width.
package legv8_pkg;

    localparam int PC_W = 64;

    // Instruction class codes, used directly as the control-word 4:1 select
    localparam logic [1:0] CLS_DIMM = 2'b00;
    localparam logic [1:0] CLS_BR   = 2'b01;
    localparam logic [1:0] CLS_MEM  = 2'b10;
    localparam logic [1:0] CLS_DREG = 2'b11;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2,
        HALT  = 2'd3
    } issue_state_t;

endpackage

// File: rtl/instr_classify_legv8.sv
// Combinational LEGv8 opcode classifier: maps op0 bits [28:25] onto the control-word select.
module instr_classify_legv8
    import legv8_pkg::*;
(
    input  logic [31:0] instr,
    output logic [1:0]  instr_class,
    output logic        unalloc
);

    // Bit 27 separates memory/register groups from immediate/branch groups
    always_comb begin
        instr_class = CLS_DIMM;
        unalloc     = 1'b0;
        if (instr[27]) begin
            instr_class = instr[25] ? CLS_DREG : CLS_MEM;
        end else if (instr[28]) begin
            instr_class = instr[26] ? CLS_BR : CLS_DIMM;
        end else begin
            unalloc = 1'b1;
        end
    end

    logic unused_fields;
    assign unused_fields = ^{instr[31:29], instr[24:0]};

endmodule

// File: rtl/instr_issue_legv8.sv
// LEGv8 fetch/issue front end: PC, imem req/ack fetch, redirect handling, one-deep issue buffer.
// Optional macro ILLEGAL_DETECT_EN adds the 'illegal' output and a HALT state for unallocated opcodes.
module instr_issue_legv8
    import legv8_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 64'h0,
    parameter int              PC_STEP  = 4
) (
    input  logic            clock,
    input  logic            reset_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_data,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            issue_valid,
    input  logic            issue_ready,
    output logic [31:0]     issue_instr,
    output logic [PC_W-1:0] issue_pc,
    output logic [1:0]      issue_class
`ifdef ILLEGAL_DETECT_EN
    ,
    output logic            illegal
`endif
);

    localparam logic [PC_W-1:0] STEP = PC_W'(PC_STEP);

    issue_state_t    state;
    logic [PC_W-1:0] pc;
    logic [1:0]      op_class;
    logic            op_unalloc;

    instr_classify_legv8 u_classify (
        .instr       (imem_data),
        .instr_class (op_class),
        .unalloc     (op_unalloc)
    );

`ifndef ILLEGAL_DETECT_EN
    logic unused_unalloc;
    assign unused_unalloc = op_unalloc;
`endif

    // imem_addr is its own register so it stays put while a dropped fetch is
    // still outstanding, even though pc has already moved to the branch target.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            issue_valid <= 1'b0;
            issue_instr <= 32'h0;
            issue_pc    <= '0;
            issue_class <= CLS_DIMM;
`ifdef ILLEGAL_DETECT_EN
            illegal     <= 1'b0;
`endif
        end else if (redirect) begin
            pc          <= redirect_pc;
            issue_valid <= 1'b0;
`ifdef ILLEGAL_DETECT_EN
            illegal     <= 1'b0;
`endif
            case (state)
                FETCH: begin
                    if (imem_req && !imem_ack) begin
                        state <= DROP;
                    end else begin
                        state    <= FETCH;
                        imem_req <= 1'b0;
                    end
                end
                DROP: begin
                    if (imem_ack) begin
                        state    <= FETCH;
                        imem_req <= 1'b0;
                    end
                end
                default: begin
                    state    <= FETCH;
                    imem_req <= 1'b0;
                end
            endcase
        end else begin
            case (state)
                FETCH: begin
                    if (!imem_req) begin
                        imem_req  <= 1'b1;
                        imem_addr <= pc;
                    end else if (imem_ack) begin
                        imem_req <= 1'b0;
                        pc       <= pc + STEP;
`ifdef ILLEGAL_DETECT_EN
                        if (op_unalloc) begin
                            state   <= HALT;
                            illegal <= 1'b1;
                        end else
`endif
                        begin
                            issue_instr <= imem_data;
                            issue_pc    <= imem_addr;
                            issue_class <= op_class;
                            issue_valid <= 1'b1;
                            state       <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (issue_ready) begin
                        issue_valid <= 1'b0;
                        state       <= FETCH;
                    end
                end
                DROP: begin
                    if (imem_ack) begin
                        imem_req <= 1'b0;
                        state    <= FETCH;
                    end
                end
`ifdef ILLEGAL_DETECT_EN
                HALT: begin
                    imem_req    <= 1'b0;
                    issue_valid <= 1'b0;
                end
`endif
                default: begin
                    state    <= FETCH;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
